// File: rtl/strassen_sequencer.sv
// Strassen 2x2 matrix multiply sequencer driving a shared external ALU.
// One ALU op per cycle over a fixed 25-step microprogram.
module strassen_sequencer #(
    parameter int         W      = 32,
    parameter logic [1:0] OP_ADD = 2'd0,
    parameter logic [1:0] OP_SUB = 2'd1,
    parameter logic [1:0] OP_MUL = 2'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a11,
    input  logic [W-1:0] a12,
    input  logic [W-1:0] a21,
    input  logic [W-1:0] a22,
    input  logic [W-1:0] b11,
    input  logic [W-1:0] b12,
    input  logic [W-1:0] b21,
    input  logic [W-1:0] b22,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c11,
    output logic [W-1:0] c12,
    output logic [W-1:0] c21,
    output logic [W-1:0] c22
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [3:0] {
        D_NONE, D_T0, D_T1, D_M1, D_M2, D_M3, D_M4,
        D_M5, D_M6, D_M7, D_C11, D_C12, D_C21, D_C22
    } dest_t;

    state_t state, state_nxt;
    dest_t  dest;
    logic [4:0] step;
    logic [W-1:0] ra11, ra12, ra21, ra22;
    logic [W-1:0] rb11, rb12, rb21, rb22;
    logic [W-1:0] t0, t1, m1, m2, m3, m4, m5, m6, m7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 5'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid)
                step <= 5'd1;
            else if (state == RUN)
                step <= (step == 5'd25) ? 5'd0 : step + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (step == 5'd25) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_ADD;
        dest      = D_NONE;
        unique case (state)
            IDLE: in_ready = 1'b1;
            DONE: out_valid = 1'b1;
            RUN: begin
                case (step)
                    5'd1:  begin alu_a = ra11; alu_b = ra22; dest = D_T0; end
                    5'd2:  begin alu_a = rb11; alu_b = rb22; dest = D_T1; end
                    5'd3:  begin alu_a = t0;   alu_b = t1;   dest = D_M1; alu_op = OP_MUL; end
                    5'd4:  begin alu_a = ra21; alu_b = ra22; dest = D_T0; end
                    5'd5:  begin alu_a = t0;   alu_b = rb11; dest = D_M2; alu_op = OP_MUL; end
                    5'd6:  begin alu_a = rb12; alu_b = rb22; dest = D_T0; alu_op = OP_SUB; end
                    5'd7:  begin alu_a = ra11; alu_b = t0;   dest = D_M3; alu_op = OP_MUL; end
                    5'd8:  begin alu_a = rb21; alu_b = rb11; dest = D_T0; alu_op = OP_SUB; end
                    5'd9:  begin alu_a = ra22; alu_b = t0;   dest = D_M4; alu_op = OP_MUL; end
                    5'd10: begin alu_a = ra11; alu_b = ra12; dest = D_T0; end
                    5'd11: begin alu_a = t0;   alu_b = rb22; dest = D_M5; alu_op = OP_MUL; end
                    5'd12: begin alu_a = ra21; alu_b = ra11; dest = D_T0; alu_op = OP_SUB; end
                    5'd13: begin alu_a = rb11; alu_b = rb12; dest = D_T1; end
                    5'd14: begin alu_a = t0;   alu_b = t1;   dest = D_M6; alu_op = OP_MUL; end
                    5'd15: begin alu_a = ra12; alu_b = ra22; dest = D_T0; alu_op = OP_SUB; end
                    5'd16: begin alu_a = rb21; alu_b = rb22; dest = D_T1; end
                    5'd17: begin alu_a = t0;   alu_b = t1;   dest = D_M7; alu_op = OP_MUL; end
                    5'd18: begin alu_a = m1;   alu_b = m4;   dest = D_C11; end
                    5'd19: begin alu_a = c11;  alu_b = m5;   dest = D_C11; alu_op = OP_SUB; end
                    5'd20: begin alu_a = c11;  alu_b = m7;   dest = D_C11; end
                    5'd21: begin alu_a = m3;   alu_b = m5;   dest = D_C12; end
                    5'd22: begin alu_a = m2;   alu_b = m4;   dest = D_C21; end
                    5'd23: begin alu_a = m1;   alu_b = m2;   dest = D_C22; alu_op = OP_SUB; end
                    5'd24: begin alu_a = c22;  alu_b = m3;   dest = D_C22; end
                    5'd25: begin alu_a = c22;  alu_b = m6;   dest = D_C22; end
                    default: dest = D_NONE;
                endcase
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand latch and result write-back; C regs accumulate in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra11 <= '0; ra12 <= '0; ra21 <= '0; ra22 <= '0;
            rb11 <= '0; rb12 <= '0; rb21 <= '0; rb22 <= '0;
            t0 <= '0; t1 <= '0;
            m1 <= '0; m2 <= '0; m3 <= '0; m4 <= '0;
            m5 <= '0; m6 <= '0; m7 <= '0;
            c11 <= '0; c12 <= '0; c21 <= '0; c22 <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                ra11 <= a11; ra12 <= a12; ra21 <= a21; ra22 <= a22;
                rb11 <= b11; rb12 <= b12; rb21 <= b21; rb22 <= b22;
            end
            unique case (dest)
                D_T0:    t0  <= alu_result;
                D_T1:    t1  <= alu_result;
                D_M1:    m1  <= alu_result;
                D_M2:    m2  <= alu_result;
                D_M3:    m3  <= alu_result;
                D_M4:    m4  <= alu_result;
                D_M5:    m5  <= alu_result;
                D_M6:    m6  <= alu_result;
                D_M7:    m7  <= alu_result;
                D_C11:   c11 <= alu_result;
                D_C12:   c12 <= alu_result;
                D_C21:   c21 <= alu_result;
                D_C22:   c22 <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_strassen_sequencer.sv
// Directed self-checking bench for strassen_sequencer with a behavioural ALU.
module tb_strassen_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a11, a12, a21, a22;
    logic [31:0] b11, b12, b21, b22;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_op;
    logic        out_valid, out_ready;
    logic [31:0] c11, c12, c21, c22;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;
    logic [1:0]  ops [25];
    logic [1:0]  exp_ops [25] = '{
        2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
        2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [31:0] s11, s12, s21, s22;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a * alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    strassen_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input int x11, x12, x21, x22, y11, y12, y21, y22);
        a11 = x11; a12 = x12; a21 = x21; a22 = x22;
        b11 = y11; b12 = y12; b21 = y21; b22 = y22;
    endtask

    // Accept one operand set, then scramble inputs to prove they were latched.
    task automatic start(input int x11, x12, x21, x22, y11, y12, y21, y22);
        set_ab(x11, x12, x21, x22, y11, y12, y21, y22);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        set_ab(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic wait_done(input string tag);
        cnt = 0;
        while (!out_valid && cnt < 60) begin
            if (cnt < 25) ops[cnt] = alu_op;
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd25);
    endtask

    task automatic check_c(input string tag, input int e11, e12, e21, e22);
        check({tag, "_c11"}, c11, e11);
        check({tag, "_c12"}, c12, e12);
        check({tag, "_c21"}, c21, e21);
        check({tag, "_c22"}, c22, e22);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check_c("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Basic run with opcode sequence trace
        start(1, 2, 3, 4, 5, 6, 7, 8);
        wait_done("basic");
        for (int i = 0; i < 25; i++)
            check($sformatf("op_step%0d", i + 1), 32'(ops[i]), 32'(exp_ops[i]));
        check("done_alu_op", 32'(alu_op), 32'd0);
        check("done_alu_a", alu_a, 32'd0);
        check_c("basic", 19, 22, 43, 50);
        drain();

        // Signed run, then backpressure in DONE
        start(-1, 2, 3, -4, 5, -6, -7, 8);
        wait_done("signed");
        check_c("signed", -19, 22, 43, -50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_c22", c22, -50);
        end
        set_ab(32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, 0, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_no_accept_in_ready", 32'(in_ready), 32'd1);
        check("hs_no_accept_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("hs_next_accept", 32'(in_ready), 32'd0);

        // Wrap: 2^16 * 2^16 truncates to zero
        wait_done("wrap");
        check_c("wrap", 0, 0, 0, 0);
        drain();

        // Back-to-back: basic then identity A
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        set_ab(1, 0, 0, 1, 5, 6, 7, 8);
        cnt = 0;
        begin
            bit seen_idle = 1'b0;
            bit done = 1'b0;
            while (!done && cnt < 100) begin
                tick();
                cnt++;
                if (out_valid) begin
                    s11 = c11; s12 = c12; s21 = c21; s22 = c22;
                end
                if (in_ready) seen_idle = 1'b1;
                else if (seen_idle) done = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_interval", 32'(cnt), 32'd27);
        check("b2b_first_c11", s11, 32'd19);
        check("b2b_first_c12", s12, 32'd22);
        check("b2b_first_c21", s21, 32'd43);
        check("b2b_first_c22", s22, 32'd50);
        wait_done("b2b2");
        check_c("b2b2", 5, 6, 7, 8);
        drain();

        // Reset during step 10
        start(1, 2, 3, 4, 5, 6, 7, 8);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_c("mid_rst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        start(1, 2, 3, 4, 5, 6, 7, 8);
        wait_done("post_rst");
        check_c("post_rst", 19, 22, 43, 50);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/strassen_sequencer.md
Name: strassen_sequencer

Overview:
- Initiator side of the shared ALU operand/op/result interface.
- Accepts one pair of 2x2 signed 32-bit matrices A and B and drives an external combinational ALU through a fixed 25-step Strassen microprogram, one ALU op per cycle.
- Returns C = A*B (low 32 bits per element) with a valid/ready handshake.
- Sits between the matrix tile loader and the result writeback in the Strassen datapath.

Parameters:
- W, 32, element and ALU data width (signed, two's complement).
- OP_ADD, 2'd0, ALU opcode for a+b.
- OP_SUB, 2'd1, ALU opcode for a-b.
- OP_MUL, 2'd2, ALU opcode for a*b.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  A/B operands valid.
- in_ready  out  1  block can accept operands.
- a11,a12,a21,a22  in  W each  matrix A, signed.
- b11,b12,b21,b22  in  W each  matrix B, signed.
- alu_a, alu_b  out  W each  ALU operands.
- alu_op  out  2  ALU opcode.
- alu_result  in  W  ALU result, combinational from alu_a/alu_b/alu_op.
- out_valid  out  1  C result valid.
- out_ready  in  1  consumer accepts C.
- c11,c12,c21,c22  out  W each  matrix C, signed.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low; all registers clear immediately on rst_n=0.
- Reset values: state=IDLE, step=0, in_ready=1, out_valid=0, c11..c22=0, alu_a=alu_b=0, alu_op=OP_ADD, all scratch registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A/B and go to RUN with step=1.
  - RUN: for steps 1..25, drive alu_a/alu_b/alu_op per the table. Capture alu_result into the destination register at the clock edge ending that cycle, then step+1. The edge ending step 25 moves to DONE.
  - DONE: out_valid=1, c11..c22 stable. On out_ready, go to IDLE.
- Handshake and latency:
  - in_ready=0 in RUN and DONE.
  - out_valid rises exactly 25 cycles after the accept edge.
  - Minimum accept-to-accept interval is 27 cycles: accept, 25 RUN cycles, 1 DONE cycle.
  - A DONE handshake and a new in_valid in the same cycle do not accept; acceptance occurs the following cycle in IDLE.
- ALU outputs outside RUN: alu_a=alu_b=0, alu_op=OP_ADD.
- Arithmetic: every result truncated to W bits (wrap). No saturation and no overflow flag. The block relies on the ALU for wrap semantics.
- Scratch registers: T0, T1, M1..M7. C registers are accumulated in place.
- Microprogram (dest = a op b):
  - Steps 1-5: 1 T0=A11+A22; 2 T1=B11+B22; 3 M1=T0*T1; 4 T0=A21+A22; 5 M2=T0*B11.
  - Steps 6-11: 6 T0=B12-B22; 7 M3=A11*T0; 8 T0=B21-B11; 9 M4=A22*T0; 10 T0=A11+A12; 11 M5=T0*B22.
  - Steps 12-17: 12 T0=A21-A11; 13 T1=B11+B12; 14 M6=T0*T1; 15 T0=A12-A22; 16 T1=B21+B22; 17 M7=T0*T1.
  - Steps 18-22: 18 C11=M1+M4; 19 C11=C11-M5; 20 C11=C11+M7; 21 C12=M3+M5; 22 C21=M2+M4.
  - Steps 23-25: 23 C22=M1-M2; 24 C22=C22+M3; 25 C22=C22+M6.
- Output registers:
  - c11..c22 are the C registers and may change during RUN.
  - Consumers sample them only on out_valid&&out_ready.
  - They hold their value from DONE until the next run writes them (step 18 onward).
- Input stability: A/B are latched at accept, so input changes after the accept edge have no effect.
- Reset mid-operation, any state: abort immediately to reset values. No partial output is signalled, and in_ready=1 on the first cycle after release.
- Unused opcode 2'd3 is never issued.

Test Plan:
- Basic: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]; out_valid exactly 25 cycles after accept; alu_op sequence matches the table.
- Signed: A=[[-1,2],[3,-4]], B=[[5,-6],[-7,8]] -> C=[[-19,22],[43,-50]].
- Wrap: A11=B11=32'h00010000, all others 0 -> C=[[0,0],[0,0]]. Step 3 product 2^32 wraps to 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and C stable, in_ready=0. Assert in_valid together with out_ready -> accept occurs on the next cycle, not the same cycle.
- Back-to-back: two operand sets (Basic, then identity A with B=[[5,6],[7,8]]) -> second C=[[5,6],[7,8]]; accept-to-accept interval 27 cycles.
- Reset mid-run: drop rst_n during step 10 -> out_valid=0, c11..c22=0, in_ready=1 after release. A following Basic run yields [[19,22],[43,50]].
